sprite_line_fetcher: RTL and testbench

//  Consumer side of the sprite ROM read interface. Per scanline, it issues one read for a sprite row.
//  It captures the returned 8-bit row into a line buffer, then serialises it as a registered

---
 rtl/sprite_line_fetcher.sv | 165 ++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//   Fetches one 8-pixel sprite row from the sprite ROM per scanline and replays it
//   as a registered per-pixel opacity flag while the display x-counter sweeps the
//   sprite's horizontal span.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   fetch_start       one-cycle fetch request (h-blank), accepted in IDLE/READY only
//   sprite_id         sprite to fetch (latched on accepted fetch_start)
//   orientation       0=UP 1=RIGHT 2=DOWN 3=LEFT (latched)
//   line_index        sprite row 0..7 (latched)
//   sprite_x          left screen column of the sprite (latched)
//   pixel_x           current display column
//   pixel_valid       high in active video
//   rom_read_enable   one-cycle ROM read strobe
//   rom_sprite_id,
//   rom_orientation,
//   rom_line_index    ROM address, held stable from the latch until the next fetch
//   rom_data          ROM row, MSB = leftmost pixel, 0 = opaque, 1 = transparent
//   busy              fetch in progress
//   line_ready        line buffer holds a valid row
//   pixel_opaque      registered: pixel_x hits an opaque pixel of the buffered row
module sprite_line_fetcher #(
  parameter int ROM_LATENCY  = 1,
  parameter int SCALE_LOG2   = 0,
  parameter int SPRITE_COUNT = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_start,
  input  logic [3:0] sprite_id,
  input  logic [1:0] orientation,
  input  logic [2:0] line_index,
  input  logic [9:0] sprite_x,
  input  logic [9:0] pixel_x,
  input  logic       pixel_valid,
  output logic       rom_read_enable,
  output logic [3:0] rom_sprite_id,
  output logic [1:0] rom_orientation,
  output logic [2:0] rom_line_index,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       line_ready,
  output logic       pixel_opaque
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_READY
  } state_t;

  localparam int         SPAN_W   = 8 << SCALE_LOG2;
  localparam logic [4:0] ID_LIMIT = 5'(SPRITE_COUNT);
  localparam logic [1:0] LAT_LAST = 2'(ROM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [1:0]  orient_q, orient_d;
  logic [2:0]  line_q, line_d;
  logic [9:0]  sx_q, sx_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  line_buf_q, line_buf_d;
  logic        pixel_opaque_q, pixel_opaque_d;

  logic        id_blank;
  logic [10:0] px_ext, sx_ext, sx_end, offset;
  logic [2:0]  col;
  logic        hit;

  // IDs beyond the populated part of the ROM are never read; they become a blank row.
  assign id_blank = ({1'b0, id_q} >= ID_LIMIT);

  // Span compare is done in 11 bits so a sprite near column 1023 clips at the
  // right edge instead of wrapping its tail around to column 0.
  assign px_ext = {1'b0, pixel_x};
  assign sx_ext = {1'b0, sx_q};
  assign sx_end = sx_ext + 11'(SPAN_W);
  assign offset = px_ext - sx_ext;
  assign col    = 3'(offset >> SCALE_LOG2);
  assign hit    = pixel_valid && (px_ext >= sx_ext) && (px_ext < sx_end);

  // Next-state logic for the fetch FSM plus the line buffer and address latch.
  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    orient_d        = orient_q;
    line_d          = line_q;
    sx_d            = sx_q;
    lat_cnt_d       = lat_cnt_q;
    line_buf_d      = line_buf_q;
    rom_read_enable = 1'b0;
    busy            = 1'b0;

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (fetch_start) begin
          id_d     = sprite_id;
          orient_d = orientation;
          line_d   = line_index;
          sx_d     = sprite_x;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        busy = 1'b1;
        if (id_blank) begin
          line_buf_d = 8'hFF;
          state_d    = ST_READY;
        end else begin
          rom_read_enable = 1'b1;
          lat_cnt_d       = 2'd0;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          line_buf_d = rom_data;
          state_d    = ST_READY;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An accepted refetch blanks the output on the very next pixel so the old row
  // is never shown once a new one has been requested.
  always_comb begin
    pixel_opaque_d = (state_q == ST_READY) && !fetch_start && hit && !line_buf_q[3'd7 - col];
  end

  // State and datapath registers; reset discards anything in flight from the ROM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      id_q           <= 4'd0;
      orient_q       <= 2'd0;
      line_q         <= 3'd0;
      sx_q           <= 10'd0;
      lat_cnt_q      <= 2'd0;
      line_buf_q     <= 8'hFF;
      pixel_opaque_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      orient_q       <= orient_d;
      line_q         <= line_d;
      sx_q           <= sx_d;
      lat_cnt_q      <= lat_cnt_d;
      line_buf_q     <= line_buf_d;
      pixel_opaque_q <= pixel_opaque_d;
    end
  end

  assign rom_sprite_id   = id_q;
  assign rom_orientation = orient_q;
  assign rom_line_index  = line_q;
  assign line_ready      = (state_q == ST_READY);
  assign pixel_opaque    = pixel_opaque_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher
//   Directed bench for sprite_line_fetcher with default parameters
//   (ROM_LATENCY=1, SCALE_LOG2=0, SPRITE_COUNT=9). A small ROM model answers
//   each strobe one cycle later.
module tb_sprite_line_fetcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_start;
  logic [3:0] sprite_id;
  logic [1:0] orientation;
  logic [2:0] line_index;
  logic [9:0] sprite_x;
  logic [9:0] pixel_x;
  logic       pixel_valid;
  logic       rom_read_enable;
  logic [3:0] rom_sprite_id;
  logic [1:0] rom_orientation;
  logic [2:0] rom_line_index;
  logic [7:0] rom_data = 8'h00;
  logic       busy;
  logic       line_ready;
  logic       pixel_opaque;

  int total = 0;
  int bad = 0;
  int strobeCount = 0;
  int savedStrobes;
  logic [7:0] expRow;

  always #5 clk = ~clk;

  sprite_line_fetcher dut (
    .clk(clk),
    .reset(reset),
    .fetch_start(fetch_start),
    .sprite_id(sprite_id),
    .orientation(orientation),
    .line_index(line_index),
    .sprite_x(sprite_x),
    .pixel_x(pixel_x),
    .pixel_valid(pixel_valid),
    .rom_read_enable(rom_read_enable),
    .rom_sprite_id(rom_sprite_id),
    .rom_orientation(rom_orientation),
    .rom_line_index(rom_line_index),
    .rom_data(rom_data),
    .busy(busy),
    .line_ready(line_ready),
    .pixel_opaque(pixel_opaque)
  );

  // ROM contents: id 3 is 8'h7E, id 5 is all-opaque, everything else a fixed mix.
  function automatic logic [7:0] romRow(input logic [3:0] id, input logic [1:0] o, input logic [2:0] l);
    if (id == 4'd3) return 8'h7E;
    if (id == 4'd5) return 8'h00;
    return {id, o, l[1:0]} ^ 8'h5A;
  endfunction

  // ROM with one cycle of latency; also counts strobes.
  always @(posedge clk) begin
    if (rom_read_enable) begin
      strobeCount <= strobeCount + 1;
      rom_data    <= romRow(rom_sprite_id, rom_orientation, rom_line_index);
    end
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic [3:0] id, input logic [1:0] o,
                               input logic [2:0] l, input logic [9:0] sx);
    fetch_start = fs;
    sprite_id   = id;
    orientation = o;
    line_index  = l;
    sprite_x    = sx;
  endtask

  task automatic sweepCheck(input string tag, input int x, input logic exp);
    pixel_x = 10'(x);
    stepClock();
    checkOutput(tag, {31'd0, pixel_opaque}, {31'd0, exp});
  endtask

  task automatic runFetch(input logic [3:0] id, input logic [1:0] o, input logic [2:0] l, input logic [9:0] sx);
    applyStimulus(1'b1, id, o, l, sx);
    stepClock();
    checkOutput("fetch req busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, id, o, l, sx);
    stepClock();
    checkOutput("fetch wait busy", {31'd0, busy}, 32'd1);
    stepClock();
    checkOutput("fetch line_ready", {31'd0, line_ready}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    pixel_x     = 10'd0;
    pixel_valid = 1'b0;
    applyStimulus(1'b0, 4'd0, 2'd0, 3'd0, 10'd0);

    // Reset state
    stepClock();
    stepClock();
    checkOutput("reset flags", {28'd0, rom_read_enable, busy, line_ready, pixel_opaque}, 32'd0);
    checkOutput("reset addr", {23'd0, rom_sprite_id, rom_orientation, rom_line_index}, 32'd0);
    reset = 1'b0;
    stepClock();

    // Fetch (2,1,5): strobe on N+1, line_ready on N+3
    applyStimulus(1'b1, 4'd2, 2'd1, 3'd5, 10'd200);
    checkOutput("t2 idle busy", {31'd0, busy}, 32'd0);
    stepClock();
    checkOutput("t2 strobe", {31'd0, rom_read_enable}, 32'd1);
    checkOutput("t2 addr", {23'd0, rom_sprite_id, rom_orientation, rom_line_index}, {23'd0, 4'd2, 2'd1, 3'd5});
    checkOutput("t2 req busy", {31'd0, busy}, 32'd1);
    checkOutput("t2 req ready", {31'd0, line_ready}, 32'd0);
    applyStimulus(1'b0, 4'd2, 2'd1, 3'd5, 10'd200);
    stepClock();
    checkOutput("t2 wait strobe", {31'd0, rom_read_enable}, 32'd0);
    checkOutput("t2 wait busy", {31'd0, busy}, 32'd1);
    checkOutput("t2 wait addr", {23'd0, rom_sprite_id, rom_orientation, rom_line_index}, {23'd0, 4'd2, 2'd1, 3'd5});
    stepClock();
    checkOutput("t2 line_ready", {31'd0, line_ready}, 32'd1);
    checkOutput("t2 ready busy", {31'd0, busy}, 32'd0);
    // Row for (2,1,5) is 8'h7F: only the leftmost pixel is opaque.
    pixel_valid = 1'b1;
    expRow = 8'h7F;
    for (int x = 199; x <= 208; x++) begin
      sweepCheck("t2 row", x, (x >= 200 && x < 208) ? !expRow[7 - (x - 200)] : 1'b0);
    end

    // Row 0111_1110 at sx=100: opaque only at 100 and 107
    runFetch(4'd3, 2'd0, 3'd0, 10'd100);
    for (int x = 96; x <= 110; x++) begin
      sweepCheck("t3 sweep", x, (x == 100 || x == 107));
    end
    pixel_valid = 1'b0;
    sweepCheck("t3 invalid", 100, 1'b0);
    pixel_valid = 1'b1;

    // Blank id 12; refetch in READY blanks the old row immediately
    pixel_x = 10'd100;
    savedStrobes = strobeCount;
    applyStimulus(1'b1, 4'd12, 2'd0, 3'd0, 10'd300);
    stepClock();
    checkOutput("t4 old row off", {31'd0, pixel_opaque}, 32'd0);
    checkOutput("t4 no strobe", {31'd0, rom_read_enable}, 32'd0);
    checkOutput("t4 req busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 4'd12, 2'd0, 3'd0, 10'd300);
    stepClock();
    checkOutput("t4 line_ready", {31'd0, line_ready}, 32'd1);
    for (int x = 299; x <= 308; x++) begin
      sweepCheck("t4 blank", x, 1'b0);
    end
    checkOutput("t4 strobe count", 32'(strobeCount), 32'(savedStrobes));

    // Clipping at sx=1020, fetch_start in WAIT ignored
    applyStimulus(1'b1, 4'd5, 2'd0, 3'd0, 10'd1020);
    stepClock();
    checkOutput("t5 req busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 4'd5, 2'd0, 3'd0, 10'd1020);
    stepClock();
    checkOutput("t5 wait busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 4'd3, 2'd2, 3'd7, 10'd10);
    stepClock();
    checkOutput("t5 ignored ready", {31'd0, line_ready}, 32'd1);
    checkOutput("t5 ignored busy", {31'd0, busy}, 32'd0);
    checkOutput("t5 ignored addr", {28'd0, rom_sprite_id}, 32'd5);
    applyStimulus(1'b0, 4'd3, 2'd2, 3'd7, 10'd10);
    sweepCheck("t5 left", 1019, 1'b0);
    for (int x = 1020; x <= 1023; x++) begin
      sweepCheck("t5 span", x, 1'b1);
    end
    for (int x = 0; x <= 3; x++) begin
      sweepCheck("t5 no wrap", x, 1'b0);
    end

    // Reset during WAIT, then a clean fetch
    applyStimulus(1'b1, 4'd2, 2'd1, 3'd5, 10'd200);
    stepClock();
    applyStimulus(1'b0, 4'd2, 2'd1, 3'd5, 10'd200);
    stepClock();
    checkOutput("t6 wait busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("t6 reset ready", {31'd0, line_ready}, 32'd0);
    checkOutput("t6 reset busy", {31'd0, busy}, 32'd0);
    checkOutput("t6 reset addr", {28'd0, rom_sprite_id}, 32'd0);
    checkOutput("t6 reset opaque", {31'd0, pixel_opaque}, 32'd0);
    runFetch(4'd3, 2'd0, 3'd0, 10'd100);
    sweepCheck("t6 x100", 100, 1'b1);
    sweepCheck("t6 x101", 101, 1'b0);
    sweepCheck("t6 x107", 107, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
